steer_sched: RTL and testbench

Clocked sequencer for the 4-way dual-rail steer stage. It queues 2-bit destination commands from the synchronous control domain and drives each one as a one-hot steer DATA wavefront into the steer stage's `steerin[3:0]`. It then completes the NCL four-phase cycle (DATA, completion high, NULL, completion low) before issuing the next command. It sits between the synchronous command source and the asynchronous steer datapath and owns the only driver of `steerin`.

---
 rtl/steer_sched.sv | 156 +++++++++++++++
 tb/tb_steer_sched.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/steer_sched.sv
// steer_sched: queues 2-bit steer commands and drives NCL DATA/NULL wavefronts.
// Define STEER_SCHED_TIMEOUT_EN to add a completion timeout with a sticky err.
module steer_sched #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       init,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_dest,
  output logic       cmd_ready,
  output logic [3:0] steer,
  input  logic       steer_comp,
  output logic       busy,
  output logic       done,
  output logic [1:0] done_dest,
  output logic       err,
  input  logic       err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_NULL
  } state_t;

  state_t                 state;
  logic [1:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [AW:0]            count;
  logic [SYNC_STAGES-1:0] sync;
  logic                   comp_s;
  logic                   push;
  logic                   pop;
  logic [1:0]             head;
  logic [1:0]             dest_q;
  logic                   tmo_data;
  logic                   tmo_null;
  logic                   aborted;

  assign comp_s    = sync[SYNC_STAGES-1];
  assign cmd_ready = (count != FULL);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == S_IDLE) & (count != '0) & ~comp_s;
  assign head      = mem[rptr];
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= cmd_dest;
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push & ~pop)
        count <= count + 1'b1;
      else if (pop & ~push)
        count <= count - 1'b1;
    end
  end

  // steer_comp comes straight from the async datapath
  always_ff @(posedge clk or posedge init) begin
    if (init) sync <= '0;
    else      sync <= {sync[SYNC_STAGES-2:0], steer_comp};
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state     <= S_IDLE;
      steer     <= '0;
      dest_q    <= '0;
      done      <= 1'b0;
      done_dest <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            steer  <= 4'b0001 << head;
            dest_q <= head;
            state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (comp_s || tmo_data) begin
            steer <= '0;
            state <= S_NULL;
          end
        end
        S_NULL: begin
          if (!comp_s) begin
            done <= ~aborted;
            if (!aborted) done_dest <= dest_q;
            state <= S_IDLE;
          end else if (tmo_null) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef STEER_SCHED_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] cnt;
  logic          at_limit;

  assign at_limit = (cnt == CW'(TIMEOUT - 1));
  assign tmo_data = (state == S_DATA) & ~comp_s & at_limit;
  assign tmo_null = (state == S_NULL) & comp_s & at_limit;

  // cnt is zero in IDLE, so entering DATA always starts from zero
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      cnt     <= '0;
      err     <= 1'b0;
      aborted <= 1'b0;
    end else begin
      if ((state == S_IDLE) || tmo_data || ((state == S_DATA) && comp_s))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (tmo_data | tmo_null)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
      if (state == S_IDLE)
        aborted <= 1'b0;
      else if (tmo_data)
        aborted <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign tmo_data   = 1'b0;
  assign tmo_null   = 1'b0;
  assign aborted    = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = err_clr ^ (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_steer_sched.sv
// tb_steer_sched: randomized stimulus against a queue-based scoreboard and a
// delayed-completion model of the steer stage.
module tb_steer_sched;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int SYNC  = 2;

  logic       clk       = 1'b0;
  logic       init      = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_dest  = 2'd0;
  logic       err_clr   = 1'b0;
  logic       cmd_ready;
  logic [3:0] steer;
  logic       steer_comp;
  logic       busy;
  logic       done;
  logic [1:0] done_dest;
  logic       err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] hist  = '0;
  int         lat   = 3;
  bit         stall = 1'b0;

  logic [1:0] mq[$];
  logic [3:0] log_q[$];
  bit         infl      = 1'b0;
  bit         abrt      = 1'b0;
  logic [1:0] infl_dest = 2'd0;
  int         done_cnt  = 0;

  steer_sched #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk       (clk),
    .init      (init),
    .cmd_valid (cmd_valid),
    .cmd_dest  (cmd_dest),
    .cmd_ready (cmd_ready),
    .steer     (steer),
    .steer_comp(steer_comp),
    .busy      (busy),
    .done      (done),
    .done_dest (done_dest),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  // Stage model: completion follows DATA/NULL on steer after lat clocks.
  always @(posedge clk) hist <= {hist[6:0], |steer};
  assign steer_comp = stall ? 1'b0 : hist[lat-1];

  initial begin : monitor
    logic [3:0] prev_steer;
    logic [3:0] want;
    bit         prev_done;
    bit         prev_err;
    prev_steer = '0;
    prev_done  = 1'b0;
    prev_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (init) begin
        mq.delete();
        infl = 1'b0;
        abrt = 1'b0;
      end else begin
        if (infl && abrt && !busy) infl = 1'b0;
        if (steer != 4'b0000 && steer != prev_steer) begin
          checks++;
          if (prev_steer != 4'b0000 || infl || mq.size() == 0) begin
            failures++;
            $display("FAIL issue: steer=%b prev=%b inflight=%0d queued=%0d (need prev 0000, none inflight, queue nonempty)",
                     steer, prev_steer, infl, mq.size());
          end else begin
            want = 4'b0001 << mq[0];
            checks++;
            if (steer !== want) begin
              failures++;
              $display("FAIL issue_dest: steer=%b expected=%b", steer, want);
            end
            infl_dest = mq.pop_front();
            infl      = 1'b1;
            abrt      = 1'b0;
            log_q.push_back(steer);
          end
        end
        if (err && !prev_err) abrt = 1'b1;
        if (done) begin
          checks++;
          if (prev_done || !infl || abrt || done_dest !== infl_dest) begin
            failures++;
            $display("FAIL done: dest=%0d expected=%0d prev_done=%0d inflight=%0d aborted=%0d",
                     done_dest, infl_dest, prev_done, infl, abrt);
          end
          infl = 1'b0;
          done_cnt++;
        end
        checks++;
        if (cmd_ready !== (mq.size() < DEPTH)) begin
          failures++;
          $display("FAIL ready: cmd_ready=%b expected=%b queued=%0d",
                   cmd_ready, (mq.size() < DEPTH), mq.size());
        end
        if (cmd_valid && mq.size() < DEPTH) mq.push_back(cmd_dest);
      end
      prev_steer = steer;
      prev_done  = done;
      prev_err   = err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] d);
    bit acc;
    int n;
    acc       = 1'b0;
    n         = 0;
    cmd_valid = 1'b1;
    cmd_dest  = d;
    do begin
      @(negedge clk);
      acc = cmd_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    cmd_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL push_wait: accepted=0 expected=1 after %0d cycles", n);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((mq.size() != 0 || infl || busy) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL drain: queued=%0d busy=%b after %0d cycles, expected idle",
               mq.size(), busy, n);
    end
  endtask

  task automatic test_reset();
    init      = 1'b1;
    cmd_valid = 1'b1;
    cmd_dest  = 2'd3;
    repeat (3) tick();
    checks++;
    if (steer !== 4'b0000) begin failures++; $display("FAIL rst_steer: %b expected 0000", steer); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: %b expected 0", busy); end
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: %b expected 1", cmd_ready); end
    checks++;
    if (done !== 1'b0 || done_dest !== 2'd0) begin
      failures++;
      $display("FAIL rst_done: done=%b dest=%0d expected 0/0", done, done_dest);
    end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL rst_err: %b expected 0", err); end
    init      = 1'b0;
    cmd_valid = 1'b0;
    repeat (8) tick();
    checks++;
    if (steer !== 4'b0000 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_empty: steer=%b busy=%b ready=%b expected 0000/0/1", steer, busy, cmd_ready);
    end
  endtask

  task automatic test_single();
    int n;
    lat       = 3;
    stall     = 1'b0;
    cmd_valid = 1'b1;
    cmd_dest  = 2'd2;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (steer !== 4'b0000) begin failures++; $display("FAIL single_nobypass: %b expected 0000", steer); end
    tick();
    checks++;
    if (steer !== 4'b0100) begin failures++; $display("FAIL single_data: %b expected 0100", steer); end
    n = 0;
    while (steer == 4'b0100 && n < 50) begin n++; tick(); end
    checks++;
    if (n != lat + SYNC + 1) begin
      failures++;
      $display("FAIL single_data_len: %0d cycles expected %0d", n, lat + SYNC + 1);
    end
    n = 0;
    while (steer == 4'b0000 && busy && !done && n < 50) begin n++; tick(); end
    checks++;
    if (n != lat + SYNC + 1) begin
      failures++;
      $display("FAIL single_null_len: %0d cycles expected %0d", n, lat + SYNC + 1);
    end
    checks++;
    if (done !== 1'b1 || done_dest !== 2'd2 || busy !== 1'b0 || steer !== 4'b0000) begin
      failures++;
      $display("FAIL single_done: done=%b dest=%0d busy=%b steer=%b expected 1/2/0/0000",
               done, done_dest, busy, steer);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL single_done_width: %b expected 0", done); end
  endtask

  task automatic test_fill();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    log_q.delete();
    lat   = 2;
    stall = 1'b1;
    push(2'd3);
    push(2'd0);
    push(2'd1);
    push(2'd2);
    push(2'd3);
    checks++;
    if (cmd_ready !== 1'b0 || steer !== 4'b1000) begin
      failures++;
      $display("FAIL fill_full: ready=%b steer=%b expected 0/1000", cmd_ready, steer);
    end
    repeat (3) tick();
    stall = 1'b0;
    wait_drain(400);
    checks++;
    if (log_q.size() != 5) begin
      failures++;
      $display("FAIL fill_count: %0d issued expected 5", log_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (log_q[i] !== exp_seq[i]) begin
          failures++;
          $display("FAIL fill_order[%0d]: %b expected %b", i, log_q[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_push_pop();
    logic [1:0] d;
    logic [1:0] d2;
    logic [3:0] exp_seq [6];
    int n;
    d  = 2'($urandom_range(0, 3));
    d2 = 2'($urandom_range(0, 3));
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001 << d, 4'b0001 << d2};
    log_q.delete();
    lat   = 2;
    stall = 1'b1;
    push(2'd0);
    push(2'd1);
    push(2'd2);
    push(2'd3);
    stall = 1'b0;
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL pp_done: done=%b expected 1", done); end
    stall = 1'b1;
    push(d);
    checks++;
    if (steer !== 4'b0010) begin failures++; $display("FAIL pp_pop: steer=%b expected 0010", steer); end
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL pp_occ3: ready=%b expected 1", cmd_ready); end
    push(d2);
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL pp_occ4: ready=%b expected 0", cmd_ready); end
    stall = 1'b0;
    wait_drain(400);
    checks++;
    if (log_q.size() != 6) begin
      failures++;
      $display("FAIL pp_count: %0d issued expected 6", log_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (log_q[i] !== exp_seq[i]) begin
          failures++;
          $display("FAIL pp_order[%0d]: %b expected %b", i, log_q[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_l[$];
    logic [1:0] d;
    int dc;
    log_q.delete();
    stall = 1'b0;
    lat   = int'($urandom_range(1, 5));
    dc    = done_cnt;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      d = 2'($urandom_range(0, 3));
      exp_l.push_back(4'b0001 << d);
      push(d);
    end
    wait_drain(2000);
    checks++;
    if (done_cnt - dc != 24) begin
      failures++;
      $display("FAIL rnd_done_count: %0d expected 24", done_cnt - dc);
    end
    checks++;
    if (log_q.size() != exp_l.size()) begin
      failures++;
      $display("FAIL rnd_count: %0d issued expected %0d", log_q.size(), exp_l.size());
    end else begin
      for (int i = 0; i < exp_l.size(); i++) begin
        checks++;
        if (log_q[i] !== exp_l[i]) begin
          failures++;
          $display("FAIL rnd_order[%0d]: %b expected %b", i, log_q[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    int dc;
    dc    = done_cnt;
    lat   = 2;
    stall = 1'b1;
    push(2'd1);
    n = 0;
    while (steer == 4'b0000 && n < 20) begin tick(); n++; end
`ifdef STEER_SCHED_TIMEOUT_EN
    n = 0;
    while (steer != 4'b0000 && n < 100) begin n++; tick(); end
    checks++;
    if (n != TMO) begin failures++; $display("FAIL tmo_len: %0d cycles expected %0d", n, TMO); end
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL tmo_err: %b expected 1", err); end
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || done_cnt != dc) begin
      failures++;
      $display("FAIL tmo_abort: busy=%b err=%b dones=%0d expected 0/1/0", busy, err, done_cnt - dc);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL tmo_clr: %b expected 0", err); end
`else
    repeat (40) tick();
    checks++;
    if (steer !== 4'b0010 || err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_wait: steer=%b err=%b expected 0010/0", steer, err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    dc = dc + 1;
`endif
    stall = 1'b0;
    push(2'd3);
    wait_drain(400);
    checks++;
    if (done_cnt != dc + 1 || err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_next: dones=%0d err=%b expected %0d/0", done_cnt - dc, err, 1);
    end
  endtask

  task automatic test_init();
    int dc;
    lat   = 2;
    stall = 1'b1;
    push(2'd0);
    push(2'd1);
    push(2'd2);
    tick();
    #2;
    init = 1'b1;
    #1;
    checks++;
    if (steer !== 4'b0000 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL init_async: steer=%b busy=%b ready=%b expected 0000/0/1", steer, busy, cmd_ready);
    end
    dc = done_cnt;
    tick();
    tick();
    init  = 1'b0;
    stall = 1'b0;
    repeat (30) tick();
    checks++;
    if (steer !== 4'b0000 || busy !== 1'b0 || done_cnt != dc) begin
      failures++;
      $display("FAIL init_flush: steer=%b busy=%b dones=%0d expected 0000/0/0",
               steer, busy, done_cnt - dc);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_push_pop();
    test_random();
    test_timeout();
    test_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
